// File: rtl/pwm_pkg.sv
// Shared types and default sizing for the PWM period counter.
package pwm_pkg;

  localparam int PWM_WIDTH    = 16;
  localparam int PWM_CHANNELS = 4;

  typedef enum logic {
    MODE_ONESHOT  = 1'b0,
    MODE_PERIODIC = 1'b1
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/pwm_channel.sv
// One PWM compare channel: double-buffered duty (shadow/active) and a
// registered compare output. The compare uses next-cycle count and duty so
// the output flop lines up with the Count register of the top.
module pwm_channel import pwm_pkg::*; #(
  parameter int WIDTH = PWM_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_copy,
  input  logic [WIDTH-1:0] i_duty,
  input  logic             i_run_nxt,
  input  logic [WIDTH-1:0] i_count_nxt,
  output logic             o_pwm
);

  logic [WIDTH-1:0] r_duty_shd;
  logic [WIDTH-1:0] r_duty_act;
  logic [WIDTH-1:0] w_duty_nxt;
  logic             r_pwm;

  // Active duty follows the shadow while idle or at a periodic reload.
  always_comb w_duty_nxt = i_copy ? r_duty_shd : r_duty_act;

  // Shadow capture, active update and output compare.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_duty_shd <= '0;
      r_duty_act <= '0;
      r_pwm      <= 1'b0;
    end else begin
      if (i_load) r_duty_shd <= i_duty;
      r_duty_act <= w_duty_nxt;
      r_pwm      <= i_run_nxt && (i_count_nxt < w_duty_nxt);
    end
  end

  assign o_pwm = r_pwm;

endmodule

// File: rtl/pwm_period_counter.sv
// Shared period counter with CHANNELS PWM compare outputs, one-shot (sticky
// Done) and periodic (Wrap pulse) modes, double-buffered MaxCount/Duty.
// Optional feature macro: PWM_IRQ_EN adds IrqClr/Irq interrupt ports.
module pwm_period_counter import pwm_pkg::*; #(
  parameter int WIDTH    = PWM_WIDTH,
  parameter int CHANNELS = PWM_CHANNELS
) (
  input  logic                      MClk,
  input  logic                      Reset,
`ifdef PWM_IRQ_EN
  input  logic                      IrqClr,
  output logic                      Irq,
`endif
  input  logic                      Enable,
  input  logic                      Mode,
  input  logic                      Load,
  input  logic [WIDTH-1:0]          MaxCount,
  input  logic [CHANNELS*WIDTH-1:0] Duty,
  output logic [WIDTH-1:0]          Count,
  output logic                      Done,
  output logic                      Wrap,
  output logic [CHANNELS-1:0]       PwmOut
);

  state_t           r_state;
  mode_t            r_mode_act;
  logic [WIDTH-1:0] r_max_shd;
  logic [WIDTH-1:0] r_max_act;
  logic [WIDTH-1:0] r_count;
  logic             r_done;
  logic             r_wrap;

  logic             w_idle;
  logic             w_at_max;
  logic             w_periodic;
  logic             w_reload;
  logic             w_to_hold;
  logic             w_run_nxt;
  logic [WIDTH-1:0] w_count_nxt;

  // Next-cycle events; shared by the FSM and the channel compares.
  always_comb begin
    w_idle      = (r_state == ST_IDLE);
    w_at_max    = (r_count == r_max_act);
    w_periodic  = (r_mode_act == MODE_PERIODIC);
    w_reload    = Enable && (r_state == ST_RUN) && w_at_max && w_periodic;
    w_to_hold   = Enable && (r_state == ST_RUN) && w_at_max && !w_periodic;
    w_run_nxt   = Enable && (w_idle || ((r_state == ST_RUN) && !w_to_hold));
    w_count_nxt = '0;
    if (Enable) begin
      case (r_state)
        ST_RUN:  w_count_nxt = w_at_max ? (w_periodic ? '0 : r_count)
                                        : r_count + WIDTH'(1);
        ST_HOLD: w_count_nxt = r_count;
        default: w_count_nxt = '0;
      endcase
    end
  end

  // Control FSM with counter, status flags and MaxCount double buffer.
  always_ff @(posedge MClk) begin
    if (Reset) begin
      r_state    <= ST_IDLE;
      r_mode_act <= MODE_ONESHOT;
      r_max_shd  <= '0;
      r_max_act  <= '0;
      r_count    <= '0;
      r_done     <= 1'b0;
      r_wrap     <= 1'b0;
    end else begin
      if (Load) r_max_shd <= MaxCount;
      if (w_idle) begin
        r_max_act  <= r_max_shd;
        r_mode_act <= mode_t'(Mode);
      end else if (w_reload) begin
        r_max_act  <= r_max_shd;
      end
      r_count <= w_count_nxt;
      r_wrap  <= w_reload;
      if (!Enable) begin
        r_state <= ST_IDLE;
        r_done  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: r_state <= ST_RUN;
          ST_RUN: if (w_to_hold) begin
            r_state <= ST_HOLD;
            r_done  <= 1'b1;
          end
          ST_HOLD: r_done <= 1'b1;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // Per-channel compare outputs.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    pwm_channel #(.WIDTH(WIDTH)) u_ch (
      .i_clk       (MClk),
      .i_rst       (Reset),
      .i_load      (Load),
      .i_copy      (w_idle || w_reload),
      .i_duty      (Duty[g*WIDTH +: WIDTH]),
      .i_run_nxt   (w_run_nxt),
      .i_count_nxt (w_count_nxt),
      .o_pwm       (PwmOut[g])
    );
  end

`ifdef PWM_IRQ_EN
  logic r_done_q;
  logic r_irq;

  // Interrupt latch: Wrap or Done rising sets it, set beats clear.
  always_ff @(posedge MClk) begin
    if (Reset) begin
      r_done_q <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_done_q <= r_done;
      if (r_wrap || (r_done && !r_done_q)) r_irq <= 1'b1;
      else if (IrqClr)                     r_irq <= 1'b0;
    end
  end

  assign Irq = r_irq;
`endif

  assign Count = r_count;
  assign Done  = r_done;
  assign Wrap  = r_wrap;

endmodule
